// File: rtl/sr_hazard_ctrl.sv
// sr_hazard_ctrl: RAW hazard / taken-branch flush control for the F-D-E-W
// schoolRISCV pipeline. A two-slot scoreboard tracks the rd of the
// instructions in E and W. The controls are combinational from that state
// and the current D fields. Saturating counters record stall and flush events.
module sr_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_useRs1_i,
  input  logic             id_useRs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_regWrite_i,
  input  logic             ex_branchTaken_i,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] stallCnt_o,
  output logic [CNT_W-1:0] flushCnt_o
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

  state_t     state, stateNext;
  logic       exBusy, wbBusy;
  logic [4:0] exRd, wbRd;
  logic       maskD, rs1Hit, rs2Hit, hazard, issue;

  // D is a killed wrong-path slot for the single cycle after a taken branch.
  assign maskD  = (state == FLUSH);

  // The register file has no write-through, so a pending write in W
  // stalls just like one in E.
  assign rs1Hit = (exBusy && exRd == id_rs1_i) || (wbBusy && wbRd == id_rs1_i);
  assign rs2Hit = (exBusy && exRd == id_rs2_i) || (wbBusy && wbRd == id_rs2_i);

  assign hazard = id_valid_i && !maskD &&
                  ((id_useRs1_i && id_rs1_i != 5'd0 && rs1Hit) ||
                   (id_useRs2_i && id_rs2_i != 5'd0 && rs2Hit));

  assign issue  = id_valid_i && !hazard && !ex_branchTaken_i && !maskD;

  // Next state and control outputs. A flush has priority over a stall.
  // All controls are held low while in reset.
  always_comb begin
    stateNext = state;
    stall_o   = 1'b0;
    bubble_o  = 1'b0;
    flush_o   = 1'b0;
    if (!rst) begin
      if (ex_branchTaken_i) begin
        flush_o  = 1'b1;
        bubble_o = 1'b1;
      end else if (hazard) begin
        stall_o  = 1'b1;
        bubble_o = 1'b1;
      end
    end
    case (state)
      RUN, STALL: begin
        if (ex_branchTaken_i) stateNext = FLUSH;
        else if (hazard)      stateNext = STALL;
        else                  stateNext = RUN;
      end
      FLUSH:   stateNext = ex_branchTaken_i ? FLUSH : RUN;
      default: stateNext = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= stateNext;
  end

  // Scoreboard shift: E moves to W. Only an issuing writer of a non-x0 rd
  // occupies E. Otherwise a bubble enters E.
  always_ff @(posedge clk) begin
    if (rst) begin
      exBusy <= 1'b0;
      exRd   <= 5'd0;
      wbBusy <= 1'b0;
      wbRd   <= 5'd0;
    end else begin
      wbBusy <= exBusy;
      wbRd   <= exRd;
      if (issue) begin
        exBusy <= id_regWrite_i && (id_rd_i != 5'd0);
        exRd   <= id_rd_i;
      end else begin
        exBusy <= 1'b0;
        exRd   <= 5'd0;
      end
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_o <= '0;
      flushCnt_o <= '0;
    end else begin
      if (stall_o && stallCnt_o != '1) stallCnt_o <= stallCnt_o + CNT_W'(1);
      if (flush_o && flushCnt_o != '1) flushCnt_o <= flushCnt_o + CNT_W'(1);
    end
  end

endmodule
